// File: rtl/uart_baud_gen_frac_if.sv
// Control and tick bundle for the fractional baud generator.
interface uart_baud_gen_frac_if #(
  parameter int DIV_W  = 16,
  parameter int FRAC_W = 4
) ();
  logic              en;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              sync_clr;
  logic              os_tick;
  logic              bit_tick;
  logic              half_tick;
  logic              div_pending;

  modport master (
    output en, div_int, div_frac, div_load, sync_clr,
    input  os_tick, bit_tick, half_tick, div_pending
  );

  modport slave (
    input  en, div_int, div_frac, div_load, sync_clr,
    output os_tick, bit_tick, half_tick, div_pending
  );
endinterface

// File: rtl/uart_baud_gen_frac.sv
// Fractional-divisor oversample tick generator with per-bit and mid-bit ticks,
// glitch-free divisor reload and a resync clear for start-bit alignment.
module uart_baud_gen_frac #(
  parameter int DIV_W       = 16,
  parameter int FRAC_W      = 4,
  parameter int OSR         = 16,
  parameter int DEFAULT_DIV = 54
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_baud_gen_frac_if.slave   bus
);
  localparam int                OS_W    = $clog2(OSR);
  localparam logic [DIV_W-1:0]  DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [OS_W-1:0]   OS_LAST = OS_W'(OSR - 1);
  localparam logic [OS_W-1:0]   OS_HALF = OS_W'(OSR / 2 - 1);

  logic [DIV_W-1:0]  r_div_int;
  logic [FRAC_W-1:0] r_div_frac;
  logic [DIV_W-1:0]  r_pend_int;
  logic [FRAC_W-1:0] r_pend_frac;
  logic              r_pend_flag;
  logic [DIV_W-1:0]  r_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic [OS_W-1:0]   r_os_cnt;
  logic              r_os_tick;
  logic              r_bit_tick;
  logic              r_half_tick;

  logic [DIV_W-1:0]  w_load_int;
  logic [DIV_W-1:0]  w_int_sel;
  logic [FRAC_W-1:0] w_frac_sel;
  logic [FRAC_W:0]   w_acc_sum;
  logic              w_boundary;
  logic              w_commit;

  // Divisors below 2 would leave no room for a down-count, so clamp on capture.
  assign w_load_int = (bus.div_int < DIV_W'(2)) ? DIV_W'(2) : bus.div_int;

  assign w_int_sel  = r_pend_flag ? r_pend_int  : r_div_int;
  assign w_frac_sel = r_pend_flag ? r_pend_frac : r_div_frac;
  assign w_acc_sum  = {1'b0, r_acc} + {1'b0, w_frac_sel};

  assign w_boundary = ~bus.sync_clr & bus.en & (r_cnt == '0);
  // Pending divisor takes effect only at a period boundary, on resync, or while idle.
  assign w_commit   = r_pend_flag & (bus.sync_clr | ~bus.en | (r_cnt == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_int   <= DEF_DIV;
      r_div_frac  <= '0;
      r_pend_int  <= DEF_DIV;
      r_pend_frac <= '0;
      r_pend_flag <= 1'b0;
    end else begin
      if (w_commit) begin
        r_div_int   <= r_pend_int;
        r_div_frac  <= r_pend_frac;
        r_pend_flag <= 1'b0;
      end
      // A new load always wins over a same-cycle commit of the older value.
      if (bus.div_load) begin
        r_pend_int  <= w_load_int;
        r_pend_frac <= bus.div_frac;
        r_pend_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= DEF_DIV - DIV_W'(1);
      r_acc    <= '0;
      r_os_cnt <= '0;
    end else if (bus.sync_clr) begin
      r_cnt    <= w_int_sel - DIV_W'(1);
      r_acc    <= '0;
      r_os_cnt <= '0;
    end else if (bus.en) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - DIV_W'(1);
      end else begin
        r_acc    <= w_acc_sum[FRAC_W-1:0];
        r_cnt    <= w_int_sel - DIV_W'(1) + DIV_W'(w_acc_sum[FRAC_W]);
        r_os_cnt <= r_os_cnt + OS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_os_tick   <= 1'b0;
      r_bit_tick  <= 1'b0;
      r_half_tick <= 1'b0;
    end else begin
      r_os_tick   <= w_boundary;
      r_bit_tick  <= w_boundary & (r_os_cnt == OS_LAST);
      r_half_tick <= w_boundary & (r_os_cnt == OS_HALF);
    end
  end

  assign bus.os_tick     = r_os_tick;
  assign bus.bit_tick    = r_bit_tick;
  assign bus.half_tick   = r_half_tick;
  assign bus.div_pending = r_pend_flag;
endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench for uart_baud_gen_frac: tick timing, fractional periods,
// reload, resync, clamp and reset, against hand-computed cycle numbers.
module tb_uart_baud_gen_frac;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_baud_gen_frac_if #(.DIV_W(16), .FRAC_W(4)) bus ();

  uart_baud_gen_frac #(
    .DIV_W(16), .FRAC_W(4), .OSR(16), .DEFAULT_DIV(54)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Record the posedge index of every observed os_tick plus its companions.
  int ts[$];
  bit bt[$];
  bit ht[$];
  always @(negedge clk) begin
    if (bus.os_tick === 1'b1) begin
      ts.push_back(cyc);
      bt.push_back(bus.bit_tick);
      ht.push_back(bus.half_tick);
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  function automatic int t_at(input int i);
    return (i < ts.size()) ? ts[i] : -1;
  endfunction

  function automatic int b_at(input int i);
    return (i < bt.size()) ? int'(bt[i]) : -1;
  endfunction

  function automatic int h_at(input int i);
    return (i < ht.size()) ? int'(ht[i]) : -1;
  endfunction

  function automatic int count_bits(input int n);
    int c = 0;
    for (int i = 0; i < n && i < bt.size(); i++) c += int'(bt[i]);
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load a divisor with the generator idle; it commits on the following edge.
  task automatic apply_div(input int di, input int df, input string tag);
    bus.en       = 1'b0;
    bus.div_int  = 16'(di);
    bus.div_frac = 4'(df);
    bus.div_load = 1'b1;
    step();
    bus.div_load = 1'b0;
    check_eq({tag, "_pend_set"}, int'(bus.div_pending), 1);
    step();
    check_eq({tag, "_pend_clr"}, int'(bus.div_pending), 0);
  endtask

  // Resync with en=1; returns the cycle at which the pulse was driven.
  task automatic sync_start(output int s);
    s = cyc;
    bus.sync_clr = 1'b1;
    bus.en       = 1'b1;
    step();
    bus.sync_clr = 1'b0;
    ts.delete();
    bt.delete();
    ht.delete();
  endtask

  int s;
  int t;
  bit found;

  initial begin
    bus.en       = 1'b0;
    bus.div_int  = '0;
    bus.div_frac = '0;
    bus.div_load = 1'b0;
    bus.sync_clr = 1'b0;

    // Reset state
    repeat (3) step();
    check_eq("rst_os_tick",   int'(bus.os_tick),     0);
    check_eq("rst_bit_tick",  int'(bus.bit_tick),    0);
    check_eq("rst_half_tick", int'(bus.half_tick),   0);
    check_eq("rst_pending",   int'(bus.div_pending), 0);

    // Default divisor 54
    reset  = 1'b0;
    bus.en = 1'b1;
    s = cyc;
    ts.delete(); bt.delete(); ht.delete();
    repeat (54 * 17 + 5) step();
    check_eq("def_first",     t_at(0) - s,         54);
    check_eq("def_period",    t_at(1) - t_at(0),   54);
    check_eq("def_16_span",   t_at(16) - t_at(0),  864);
    check_eq("def_bit_16th",  b_at(15),            1);
    check_eq("def_half_8th",  h_at(7),             1);
    check_eq("def_bit_count", count_bits(16),      1);
    check_eq("def_pending",   int'(bus.div_pending), 0);

    // Integer divisor 10
    apply_div(10, 0, "d10");
    sync_start(s);
    repeat (330) step();
    check_eq("d10_first",     t_at(0) - s,          11);
    check_eq("d10_period",    t_at(1) - t_at(0),    10);
    check_eq("d10_bit_a",     b_at(15),             1);
    check_eq("d10_bit_b",     b_at(31),             1);
    check_eq("d10_bit_gap",   t_at(31) - t_at(15),  160);
    check_eq("d10_bit_count", count_bits(32),       2);

    // Fractional 10.5
    apply_div(10, 8, "f8");
    sync_start(s);
    repeat (185) step();
    check_eq("f8_p0",   t_at(1) - t_at(0),  10);
    check_eq("f8_p1",   t_at(2) - t_at(1),  11);
    check_eq("f8_p2",   t_at(3) - t_at(2),  10);
    check_eq("f8_span", t_at(16) - t_at(0), 168);

    // Fractional 10.25
    apply_div(10, 4, "f4");
    sync_start(s);
    repeat (60) step();
    check_eq("f4_p2",   t_at(3) - t_at(2), 10);
    check_eq("f4_p3",   t_at(4) - t_at(3), 11);
    check_eq("f4_span", t_at(4) - t_at(0), 41);

    // Runtime reload 10 -> 20 mid-period; ticks at s+11, s+21, s+31, then +20
    apply_div(10, 0, "rl");
    sync_start(s);
    repeat (24) step();
    bus.div_int  = 16'd20;
    bus.div_frac = 4'd0;
    bus.div_load = 1'b1;
    step();
    bus.div_load = 1'b0;
    check_eq("rl_pend_hi",     int'(bus.div_pending), 1);
    repeat (4) step();
    check_eq("rl_pend_still",  int'(bus.div_pending), 1);
    step();
    check_eq("rl_pend_fall",   int'(bus.div_pending), 0);
    check_eq("rl_tick_commit", int'(bus.os_tick),     1);
    repeat (45) step();
    check_eq("rl_old_period",  t_at(2) - t_at(1), 10);
    check_eq("rl_new_period",  t_at(3) - t_at(2), 20);
    check_eq("rl_new_period2", t_at(4) - t_at(3), 20);

    // Resync at os_cnt=5 with 10.5; periods 10,11,10,11,10 before it
    apply_div(10, 8, "rs");
    sync_start(s);
    repeat (56) step();
    check_eq("rs_pre_ticks", ts.size(), 5);
    t = cyc;
    bus.sync_clr = 1'b1;
    step();
    bus.sync_clr = 1'b0;
    ts.delete(); bt.delete(); ht.delete();
    repeat (185) step();
    check_eq("rs_first",    t_at(0) - t,          11);
    check_eq("rs_acc_p0",   t_at(1) - t_at(0),    10);
    check_eq("rs_acc_p1",   t_at(2) - t_at(1),    11);
    check_eq("rs_half_8th", h_at(7),              1);
    check_eq("rs_bit_16th", b_at(15),             1);
    check_eq("rs_bit_cnt",  count_bits(16),       1);

    // Clamp: 0 and 1 behave as 2
    apply_div(0, 0, "c0");
    sync_start(s);
    repeat (10) step();
    check_eq("c0_first",  t_at(0) - s,        3);
    check_eq("c0_period", t_at(1) - t_at(0),  2);
    apply_div(1, 0, "c1");
    sync_start(s);
    repeat (10) step();
    check_eq("c1_first",  t_at(0) - s,        3);
    check_eq("c1_period", t_at(1) - t_at(0),  2);

    // Simultaneous load and resync: resync uses the old divisor (2)
    s = cyc;
    bus.div_int  = 16'd10;
    bus.div_frac = 4'd0;
    bus.div_load = 1'b1;
    bus.sync_clr = 1'b1;
    step();
    bus.div_load = 1'b0;
    bus.sync_clr = 1'b0;
    ts.delete(); bt.delete(); ht.delete();
    check_eq("ls_pend", int'(bus.div_pending), 1);
    repeat (20) step();
    check_eq("ls_first",  t_at(0) - s,       3);
    check_eq("ls_period", t_at(1) - t_at(0), 10);

    // Asynchronous reset while os_tick is high
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.os_tick === 1'b1) found = 1'b1;
      else step();
    end
    check_eq("ar_tick_before", int'(bus.os_tick), 1);
    reset = 1'b1;
    #1;
    check_eq("ar_tick_async", int'(bus.os_tick),     0);
    check_eq("ar_pend_async", int'(bus.div_pending), 0);
    step();
    step();
    reset = 1'b0;
    s = cyc;
    ts.delete(); bt.delete(); ht.delete();
    repeat (60) step();
    check_eq("ar_ticks", ts.size(),   1);
    check_eq("ar_first", t_at(0) - s, 54);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_baud_gen_frac.md
Name: uart_baud_gen_frac

Overview:
- Parametrised successor to the team's integer baud tick generator.
- Produces an oversample tick (os_tick) from a fractional divisor: integer part plus FRAC_W-bit fraction, using an error accumulator. Also produces a per-bit tick (bit_tick) and a mid-bit sample tick (half_tick).
- Supports glitch-free runtime divisor reload and a resync clear, so the UART RX can realign its bit timing on a start-bit edge.
- Example: 100 MHz clock, 115200 baud x16 -> div_int=54, div_frac=4 (54.25).

Parameters:
- DIV_W, 16, width of integer divisor and down-counter.
- FRAC_W, 4, width of fractional divisor and accumulator (fraction unit = 1/2^FRAC_W).
- OSR, 16, os_ticks per bit; power of two, >=4.
- DEFAULT_DIV, 54, integer divisor after reset; must be >=2.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- en  in  1  run enable; when low, counters hold and no ticks are produced
- div_int  in  DIV_W  integer divisor, sampled on div_load
- div_frac  in  FRAC_W  fractional divisor, sampled on div_load
- div_load  in  1  single-cycle pulse that captures div_int/div_frac into the pending register
- sync_clr  in  1  resync pulse; restarts the bit timing
- os_tick  out  1  oversample tick, one cycle wide, registered
- bit_tick  out  1  one cycle wide, coincident with every OSR-th os_tick
- half_tick  out  1  one cycle wide, coincident with os_tick at mid-bit
- div_pending  out  1  high while a loaded divisor is waiting to be applied

Behaviour:
- State: div_int_q, div_frac_q (active divisor), pend_int, pend_frac, pend_flag, cnt[DIV_W], acc[FRAC_W], os_cnt[log2(OSR)].
- Reset (async): div_int_q=DEFAULT_DIV, div_frac_q=0, cnt=DEFAULT_DIV-1, acc=0, os_cnt=0, pend_flag=0; all outputs 0.
- Clamp: div_int values 0 or 1 are stored as 2 when captured.
- Load: div_load captures the clamped div_int and div_frac into the pending register and sets pend_flag.
  - A second load while pending overwrites the pending value.
  - div_pending = pend_flag (registered).
- Tick generation, each cycle with en=1 and sync_clr=0:
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0, then:
    - Select divisor: if pend_flag, use and commit the pending divisor (div_int_q/div_frac_q <= pending, pend_flag<=0); else use the active divisor.
    - {carry,acc} <= acc + frac_sel.
    - cnt <= int_sel - 1 + carry.
    - os_tick <= 1 in the next cycle.
- Timing:
  - Period between os_tick rising edges = int_sel + carry cycles; long-run average = div_int + div_frac/2^FRAC_W.
  - First os_tick after reset occurs DEFAULT_DIV cycles after the first cycle with en=1.
- os_cnt increments on each os_tick and wraps from OSR-1 to 0.
  - bit_tick = os_tick & (os_cnt==OSR-1).
  - half_tick = os_tick & (os_cnt==OSR/2-1).
  - Both are registered alongside os_tick, i.e. in the same cycle as the os_tick they accompany.
- en=0:
  - cnt, acc, os_cnt hold; os_tick, bit_tick, half_tick are 0 the next cycle.
  - A pending divisor is committed immediately (one cycle after div_load) while en=0.
- sync_clr (priority over en and tick):
  - cnt <= div_int_q-1, acc <= 0, os_cnt <= 0.
  - No tick is generated from that cycle.
  - A pending divisor is committed first, then used for the reload.
  - Counting resumes the next cycle, so the first os_tick arrives div_int cycles after the sync_clr cycle.
- Simultaneous div_load and a reload boundary: the boundary uses the old pending/active value; the new value becomes pending.
- Simultaneous div_load and sync_clr: the new value is captured as pending and is not used by this sync_clr.
- Reset mid-operation: immediate return to reset values; outputs deassert asynchronously.

Test Plan:
- Reset, then en=1 with DEFAULT_DIV=54, OSR=16 -> first os_tick 54 cycles after en; period 54; bit_tick every 864 cycles; half_tick on 8th os_tick of each bit; div_pending=0.
- Load div_int=10, div_frac=0 while en=0, then en=1 -> os_tick every 10 cycles; bit_tick every 160 cycles, coincident with every 16th os_tick.
- Load div_int=10, div_frac=8 (FRAC_W=4) -> os_tick periods alternate 10,11,10,11; 16 os_ticks span exactly 168 cycles; repeat with frac=4 -> periods 10,10,10,11.
- While running at 10, load 20 mid-period -> div_pending=1 until the current period ends; that period is still 10 and the next is 20; div_pending falls on the commit cycle.
- Assert sync_clr at os_cnt=5 mid-period -> no tick that cycle; next os_tick 10 cycles later with os_cnt restarted (half_tick on its 8th os_tick, bit_tick on its 16th); acc zeroed.
- Load div_int=0 and div_int=1 -> both behave as 2 (os_tick every 2 cycles). Assert reset mid-period with en=1 -> all outputs 0 immediately; timing restarts at DEFAULT_DIV.
